// File: rtl/ysyx_25040129_rtc_if.sv
// ysyx_25040129 RTC bus: read-only AXI4-Lite AR/R channels.
// The crossbar is the master; the RTC device is the slave.
interface ysyx_25040129_rtc_if;
  logic [31:0] rtc_araddr;
  logic        rtc_arvalid;
  logic        rtc_arready;
  logic [31:0] rtc_rdata;
  logic [1:0]  rtc_rresp;
  logic        rtc_rvalid;
  logic        rtc_rready;

  modport master (
    output rtc_araddr,
    output rtc_arvalid,
    input  rtc_arready,
    input  rtc_rdata,
    input  rtc_rresp,
    input  rtc_rvalid,
    output rtc_rready
  );

  modport slave (
    input  rtc_araddr,
    input  rtc_arvalid,
    output rtc_arready,
    output rtc_rdata,
    output rtc_rresp,
    output rtc_rvalid,
    input  rtc_rready
  );
endinterface

// File: rtl/ysyx_25040129_rtc.sv
// ysyx_25040129 RTC: free-running 64-bit prescaled timer behind AXI4-Lite reads.
// A high-word read snapshots mtime so the following low-word read is coherent.
module ysyx_25040129_rtc #(
  parameter int unsigned DIV = 1,
  parameter int unsigned LAT = 0
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_25040129_rtc_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [15:0] PMAX = 16'(DIV - 1);
  localparam logic [3:0]  LMAX = 4'((LAT == 0) ? 0 : LAT - 1);

  logic [15:0] prescale;
  logic [63:0] mtime;
  logic        tick;
  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] snap;
  logic        snap_valid;
  logic [2:0]  off;
  logic        unused_addr;

  assign tick        = (prescale == PMAX);
  assign off         = bus.rtc_araddr[2:0];
  assign unused_addr = ^bus.rtc_araddr[31:3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
      mtime    <= '0;
    end else if (tick) begin
      prescale <= '0;
      mtime    <= mtime + 64'd1;
    end else begin
      prescale <= prescale + 16'd1;
    end
  end

  // Responses use the pre-edge mtime, so a tick on the AR edge is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      snap            <= '0;
      snap_valid      <= 1'b0;
      bus.rtc_arready <= 1'b0;
      bus.rtc_rvalid  <= 1'b0;
      bus.rtc_rdata   <= '0;
      bus.rtc_rresp   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.rtc_arready) begin
            bus.rtc_arready <= 1'b1;
          end else if (bus.rtc_arvalid) begin
            bus.rtc_arready <= 1'b0;
            bus.rtc_rresp   <= 2'b00;
            unique case (1'b1)
              (off == 3'd0): begin
                bus.rtc_rdata <= snap_valid ? snap[31:0]
                                            : mtime[31:0];
                snap_valid    <= 1'b0;
              end
              (off == 3'd4): begin
                snap          <= mtime;
                snap_valid    <= 1'b1;
                bus.rtc_rdata <= mtime[63:32];
              end
              default: begin
                bus.rtc_rdata <= '0;
                bus.rtc_rresp <= 2'b10;
              end
            endcase
            if (LAT == 0) begin
              state          <= RESP;
              bus.rtc_rvalid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LMAX;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state          <= RESP;
            bus.rtc_rvalid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rtc_rready) begin
            bus.rtc_rvalid  <= 1'b0;
            bus.rtc_arready <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_rtc.sv
// Directed bench for ysyx_25040129_rtc.
// Three instances cover DIV=1/LAT=0, DIV=4/LAT=0 and DIV=1/LAT=3.
module tb_ysyx_25040129_rtc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_25040129_rtc_if b0 ();
  ysyx_25040129_rtc_if b1 ();
  ysyx_25040129_rtc_if b2 ();

  ysyx_25040129_rtc #(.DIV(1), .LAT(0)) u_d1 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );
  ysyx_25040129_rtc #(.DIV(4), .LAT(0)) u_d4 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );
  ysyx_25040129_rtc #(.DIV(1), .LAT(3)) u_l3 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  logic [31:0] araddr [3];
  logic [2:0]  arvalid;
  logic [2:0]  rready;
  logic [2:0]  arready;
  logic [2:0]  rvalid;
  logic [31:0] rdata [3];
  logic [1:0]  rresp [3];

  assign b0.rtc_araddr  = araddr[0];
  assign b1.rtc_araddr  = araddr[1];
  assign b2.rtc_araddr  = araddr[2];
  assign b0.rtc_arvalid = arvalid[0];
  assign b1.rtc_arvalid = arvalid[1];
  assign b2.rtc_arvalid = arvalid[2];
  assign b0.rtc_rready  = rready[0];
  assign b1.rtc_rready  = rready[1];
  assign b2.rtc_rready  = rready[2];
  assign arready = {b2.rtc_arready, b1.rtc_arready, b0.rtc_arready};
  assign rvalid  = {b2.rtc_rvalid, b1.rtc_rvalid, b0.rtc_rvalid};
  assign rdata[0] = b0.rtc_rdata;
  assign rdata[1] = b1.rtc_rdata;
  assign rdata[2] = b2.rtc_rdata;
  assign rresp[0] = b0.rtc_rresp;
  assign rresp[1] = b1.rtc_rresp;
  assign rresp[2] = b2.rtc_rresp;

  // Edges since reset release; during a cycle it equals mtime*DIV+prescale.
  longint unsigned edges;
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input longint unsigned t);
    for (int n = 0; n < 500 && edges + 1 < t; n++) @(negedge clk);
  endtask

  task automatic ar(input int d, input logic [2:0] off,
                    output longint unsigned mt);
    bit ok;
    ok = 1'b0;
    mt = 0;
    @(negedge clk);
    araddr[d]  = 32'h0200_0000 | {29'd0, off};
    arvalid[d] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (arready[d]) begin
        mt = edges;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ar_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 arvalid[d] = 1'b0;
  endtask

  task automatic rv(input int d, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rvalid[d]) begin
        lat = n;
        break;
      end
    end
    chk("rvalid_seen", 64'(lat >= 0), 64'd1);
  endtask

  task automatic rd(input int d, input logic [2:0] off,
                    output longint unsigned mt,
                    output logic [31:0] data,
                    output logic [1:0] resp, output int lat);
    ar(d, off, mt);
    rv(d, lat);
    data = rdata[d];
    resp = rresp[d];
    @(posedge clk);
    #1;
  endtask

  longint unsigned mt, mt2, snap, snap6, exp6;
  logic [31:0] data, held;
  logic [1:0]  resp;
  int          lat, nresp, k;
  bit          stray;

  initial begin
    for (int d = 0; d < 3; d++) araddr[d] = '0;
    arvalid = '0;
    rready  = 3'b111;

    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata[0]), 64'd0);
    chk("rst_rresp", 64'(rresp[2]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arready_up", 64'(arready), 64'h7);

    // basic read, DIV=1 and DIV=4
    wait_until(10);
    rd(0, 3'd0, mt, data, resp, lat);
    chk("t1_rdata", 64'(data), 64'd10);
    chk("t1_rresp", 64'(resp), 64'd0);
    chk("t1_lat", 64'(lat), 64'd0);
    wait_until(14);
    rd(1, 3'd0, mt, data, resp, lat);
    chk("t1_div4", 64'(data), 64'd3);
    chk("t1_div4_mt", 64'(data), mt / 4);
    rd(1, 3'd4, mt, data, resp, lat);
    chk("t1_div4_hi", 64'(data), 64'd0);

    // coherent snapshot
    wait_until(20);
    rd(0, 3'd4, mt, data, resp, lat);
    snap = mt;
    chk("t2_hi", 64'(data), mt >> 32);
    chk("t2_hi_resp", 64'(resp), 64'd0);
    wait_until(30);
    rd(0, 3'd0, mt, data, resp, lat);
    chk("t2_snap", 64'(data), 64'd20);
    wait_until(40);
    rd(0, 3'd0, mt, data, resp, lat);
    chk("t2_live", 64'(data), 64'd40);

    // misaligned, snapshot preserved
    rd(0, 3'd4, mt, data, resp, lat);
    snap = mt;
    rd(0, 3'd2, mt, data, resp, lat);
    chk("t3_mis_data", 64'(data), 64'd0);
    chk("t3_mis_resp", 64'(resp), 64'd2);
    rd(0, 3'd7, mt, data, resp, lat);
    chk("t3_mis7_resp", 64'(resp), 64'd2);
    rd(0, 3'd0, mt, data, resp, lat);
    chk("t3_snap", 64'(data), snap & 64'hffff_ffff);
    chk("t3_snap_resp", 64'(resp), 64'd0);

    // latency and backpressure
    rready[2] = 1'b0;
    ar(2, 3'd0, mt);
    rv(2, lat);
    chk("t4_lat", 64'(lat), 64'd3);
    held = rdata[2];
    chk("t4_rdata", 64'(held), mt);
    araddr[2]  = 32'h0200_0004;
    arvalid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(rvalid[2]), 64'd1);
      chk("t4_hold_data", 64'(rdata[2]), 64'(held));
      chk("t4_no_arready", 64'(arready[2]), 64'd0);
    end
    arvalid[2] = 1'b0;
    rready[2]  = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_rvalid_drop", 64'(rvalid[2]), 64'd0);
    chk("t4_arready_back", 64'(arready[2]), 64'd1);
    rd(2, 3'd0, mt2, data, resp, lat);
    chk("t4_no_stray_snap", 64'(data), mt2);

    // reset while a response is pending
    rready[0] = 1'b0;
    ar(0, 3'd4, mt);
    rv(0, lat);
    #2 rst = 1'b0;
    #1;
    chk("t5_rvalid", 64'(rvalid[0]), 64'd0);
    chk("t5_arready", 64'(arready[0]), 64'd0);
    chk("t5_rdata", 64'(rdata[0]), 64'd0);
    @(negedge clk);
    rst       = 1'b1;
    rready[0] = 1'b1;
    stray     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rvalid[0]) stray = 1'b1;
    end
    chk("t5_no_beat", 64'(stray), 64'd0);
    wait_until(5);
    rd(0, 3'd0, mt, data, resp, lat);
    chk("t5_fresh", 64'(data), 64'd5);

    // back-to-back with arvalid held high
    nresp = 0;
    k     = 0;
    exp6  = 0;
    snap6 = 0;
    arvalid[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rvalid[0]) begin
        chk("t6_rdata", 64'(rdata[0]), exp6);
        nresp++;
      end
      if (arready[0]) begin
        if (k % 2 == 0) begin
          araddr[0] = 32'h0200_0004;
          snap6     = edges;
          exp6      = edges >> 32;
        end else begin
          araddr[0] = 32'h0200_0000;
          exp6      = snap6 & 64'hffff_ffff;
        end
        k++;
      end
    end
    arvalid[0] = 1'b0;
    chk("t6_beats", 64'(nresp), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_rtc.md
# ysyx_25040129_rtc

Read-only AXI4-Lite responder that implements the RTC device behind the crossbar's RTC port. It keeps a free-running 64-bit timer and returns its low or high word on AR/R handshakes. A snapshot of the full value is taken on every high-word read, so software reading the high word and then the low word gets a coherent 64-bit value. The block has no write channel; writes to the RTC range are rejected upstream.

## Interface
Parameters:
- `DIV`, default 1: timer prescaler. The timer increments once every `DIV` clock cycles. Legal range 1..65535.
- `LAT`, default 0: extra wait cycles between AR acceptance and `rvalid`. Legal range 0..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `rtc_araddr`  in  32  read address. Only bits [2:0] are decoded; the crossbar has already decoded the range.
- `rtc_arvalid`  in  1  address valid
- `rtc_arready`  out  1  address ready (registered)
- `rtc_rdata`  out  32  read data (registered)
- `rtc_rresp`  out  2  2'b00 OKAY, 2'b10 SLVERR (registered)
- `rtc_rvalid`  out  1  read data valid (registered)
- `rtc_rready`  in  1  read data ready

## Operation
Timer:
- `prescale` counts 0..DIV-1. When `prescale == DIV-1`, it wraps to 0 and `mtime` (64-bit) increments.
- With `DIV=1`, `mtime` increments on every edge.
- `mtime` wraps from 2^64-1 to 0 silently.
- The timer never stalls, whatever the bus activity.

Address decode, with `off = rtc_araddr[2:0]`:
- `off == 0`, low word: returns `snap[31:0]` if `snap_valid` is set, and clears `snap_valid`. Otherwise returns live `mtime[31:0]`. `rresp` = OKAY.
- `off == 4`, high word: captures `snap <= mtime`, sets `snap_valid`, returns `mtime[63:32]`. `rresp` = OKAY.
- Any other `off` (misaligned): `rdata` = 0, `rresp` = SLVERR. `snap` and `snap_valid` are unchanged.
- "mtime" above always means its value in the AR handshake cycle.

State machine (`IDLE`, `WAIT`, `RESP`):
- `IDLE`: `arready`=1. On `arvalid`: compute the response, clear `arready`, then go to `WAIT` if `LAT>0`, else to `RESP` with `rvalid`=1.
- `WAIT`: a 4-bit counter loads `LAT-1` and counts down. At 0, go to `RESP` and set `rvalid`=1.
- `RESP`: hold `rvalid`, `rdata` and `rresp` stable until `rready`. On `rvalid && rready`: clear `rvalid`, set `arready`, go to `IDLE`.
- Only one outstanding transaction. `arvalid` is ignored outside `IDLE`.

## Timing
Reset (`rst` low, asynchronous) sets:
- state `IDLE`
- `arready`=0, `rvalid`=0, `rdata`=0, `rresp`=0
- `mtime`=0, `prescale`=0, `snap`=0, `snap_valid`=0

After reset:
- `arready` rises on the first `clk` edge after `rst` deasserts.
- `mtime` first increments on edge number `DIV` after deassertion. At edge n, `mtime = floor(n/DIV)`.

Handshake timing, for an AR handshake in cycle T:
- `rvalid` is high from cycle T+1+`LAT`.
- Lowest latency is 1 cycle.
- After an R handshake in cycle R, `arready` is 1 in cycle R+1, so the next AR can be accepted in R+1.

Reset mid-transaction:
- Any in-flight response is dropped immediately.
- No R beat is produced after reset releases.

Simultaneous events:
- A timer tick in the handshake cycle is not visible in that response; the pre-edge value is used.
- A high-word read in the same cycle as a tick captures the pre-edge `mtime`.

## Test plan
1. **Basic read:** `DIV=1`, `LAT=0`; release reset; AR `off=0` with handshake at edge 10 -> `rvalid` next cycle, `rdata`=10, `rresp`=00. Repeat with `DIV=4` -> `rdata`=2.
2. **Coherent snapshot:** `DIV=1`; read `off=4` at edge 20 -> `rdata`=0. Read `off=0` at edge 30 -> `rdata`=20 (snapshot). Read `off=0` at edge 40 -> `rdata`=40 (live).
3. **Misaligned read:** `off=2` -> `rresp`=2'b10, `rdata`=0. A pending snapshot from a prior `off=4` read is still returned by the next `off=0` read.
4. **Latency and backpressure:** `LAT=3`, `rready` low for 5 cycles after `rvalid` -> `rvalid` rises at T+4 and `rdata` stays constant. `arready` stays 0 and a second `arvalid` is not accepted. After `rready`, `rvalid` falls and `arready`=1 on the next cycle.
5. **Reset mid-operation:** assert `rst` while `rvalid`=1 -> `rvalid`, `arready` and `mtime` go to 0 without a clock edge. After release, `off=0` at edge 5 -> 5 (no stale snapshot).
6. **Back-to-back reads:** `rready` tied high, `arvalid` held high, alternating `off=4` / `off=0` -> one response every 2 cycles. Each low word equals the `mtime` captured by the preceding high read.
